// File: rtl/pc_fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
package pc_fetch_pkg;

  localparam int INST_W = 32;

  // Boot vector and the exception vectors that live in the boot ROM.
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC_TLB  = 32'hBFC0_0200;
  localparam logic [31:0] EXC_VEC_GEN  = 32'hBFC0_0380;

  // Word returned for a fetch that has no valid instruction.
  localparam logic [INST_W-1:0] INST_NONE = '0;

  // A fetch address is usable only when it is word aligned.
  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold buffer: keeps the returned SRAM word stable across stalls
// and selects the instruction presented to IF/ID.
module fetch_hold_buf
  import pc_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rset,
  input  logic              advance,
  input  logic              resp_valid,
  input  logic              illegal,
  input  logic [INST_W-1:0] rdata,
  output logic [INST_W-1:0] inst
);

  logic              hold_valid;
  logic [INST_W-1:0] hold_inst;

  // Capture the SRAM word on the first hold cycle; drop it on any advance.
  always_ff @(posedge clk) begin
    if (rset) begin
      hold_valid <= 1'b0;
      hold_inst  <= INST_NONE;
    end else if (advance) begin
      hold_valid <= 1'b0;
    end else if (!hold_valid && resp_valid) begin
      hold_valid <= 1'b1;
      hold_inst  <= rdata;
    end
  end

  // Nothing valid or a misaligned PC shows an all-zero word.
  always_comb begin
    inst = INST_NONE;
    if (resp_valid && !illegal) begin
      inst = hold_valid ? hold_inst : rdata;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the fetch PC, chooses the next PC and
// presents {instruction, PC, illegal_pc, in_delayslot} to IF/ID.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rset,
  input  logic              stall,
  input  logic              exc_valid,
  input  logic [31:0]       exc_pc,
  input  logic              id_is_branch,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic              inst_sram_en,
  output logic [31:0]       inst_sram_addr,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic [INST_W-1:0] instruction_out,
  output logic [31:0]       PC_out,
  output logic              illegal_pc_out,
  output logic              in_delayslot_out
);

  logic [31:0] pc_r;
  logic        resp_valid;
  logic        ds_r;
  logic [31:0] npc;
  logic        advance;

  // "stall" is the IF/ID capture strobe; a redirect moves fetch regardless.
  assign advance = stall | exc_valid;

  // Next PC: redirect beats taken branch beats sequential (wraps mod 2^32).
  always_comb begin
    npc = pc_r + 32'd4;
    if (exc_valid) begin
      npc = exc_pc;
    end else if (branch_taken && id_is_branch) begin
      npc = branch_target;
    end
  end

  // Misaligned addresses are never sent to the SRAM.
  assign inst_sram_addr = npc;
  assign inst_sram_en   = !rset && advance && is_aligned(npc);

  // Fetch PC, response-valid and delay-slot tracking.
  always_ff @(posedge clk) begin
    if (rset) begin
      pc_r       <= RESET_PC - 32'd4;
      resp_valid <= 1'b0;
      ds_r       <= 1'b0;
    end else if (advance) begin
      pc_r       <= npc;
      resp_valid <= 1'b1;
      ds_r       <= id_is_branch && !exc_valid;
    end
  end

  assign PC_out           = pc_r;
  assign illegal_pc_out   = resp_valid && !is_aligned(pc_r);
  assign in_delayslot_out = resp_valid && ds_r;

  fetch_hold_buf u_hold (
    .clk        (clk),
    .rset       (rset),
    .advance    (advance),
    .resp_valid (resp_valid),
    .illegal    (illegal_pc_out),
    .rdata      (inst_sram_rdata),
    .inst       (instruction_out)
  );

endmodule
